// File: rtl/cdc_rst_sequencer.sv
// Ordered reset-release sequencer: holds all downstream stages in reset, then
// releases them one at a time, waiting for each stage's ready ack with a timeout.
module cdc_rst_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ready_in,
  output logic [NUM_STAGES-1:0] stage_rst_n_out,
  output logic                  busy,
  output logic                  all_ready,
  output logic                  timeout_err,
  output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] fail_stage
);

  localparam int unsigned NS       = NUM_STAGES;
  localparam int unsigned IW       = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned MAX_CNT  = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CW       = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

  if (NUM_STAGES < 1 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("cdc_rst_sequencer: NUM_STAGES, HOLD_CYCLES and TIMEOUT_CYCLES must all be >= 1");
  end

  typedef enum logic [1:0] {S_HOLD, S_WAIT, S_DONE, S_ERROR} state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic [IW-1:0] idx;

  // Released stages always form a thermometer code, so the next release is a shift-in of 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_HOLD;
      stage_rst_n_out <= '0;
      counter         <= '0;
      idx             <= '0;
      busy            <= 1'b1;
      all_ready       <= 1'b0;
      timeout_err     <= 1'b0;
      fail_stage      <= '0;
    end else if (sw_rst_req) begin
      state           <= S_HOLD;
      stage_rst_n_out <= '0;
      counter         <= '0;
      idx             <= '0;
      busy            <= 1'b1;
      all_ready       <= 1'b0;
      timeout_err     <= 1'b0;
      fail_stage      <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (counter == HOLD_LAST) begin
            stage_rst_n_out <= NS'(1);
            idx             <= '0;
            counter         <= '0;
            state           <= S_WAIT;
          end else begin
            counter <= counter + CW'(1);
          end
        end
        S_WAIT: begin
          // Ready takes precedence over a timeout expiring on the same edge.
          if (stage_ready_in[idx]) begin
            if (idx == IDX_LAST) begin
              state     <= S_DONE;
              all_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              stage_rst_n_out <= (stage_rst_n_out << 1) | NS'(1);
              idx             <= idx + IW'(1);
              counter         <= '0;
            end
          end else if (counter == TO_LAST) begin
            state       <= S_ERROR;
            timeout_err <= 1'b1;
            fail_stage  <= idx;
            busy        <= 1'b0;
          end else begin
            counter <= counter + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
